regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two read ports plus a read port at the write address, all registered.
// Lane-masked writes, same-cycle write bypass, and a swept clear after reset or on request.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | sweeping ptr_q from 0 to DEPTH-1, zeroing one entry per cycle
// S_READY | array usable; writes accepted, clr starts a new sweep
module regfile_mp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 4,
   parameter int LANE_W  = 16,
   parameter int ZERO_R0 = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   input  logic [ADDR_W-1:0]          raddr1,
   input  logic [ADDR_W-1:0]          raddr2,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/LANE_W-1:0]   wmask,
   input  logic                       we,
   output logic [DATA_W-1:0]          rdata1,
   output logic [DATA_W-1:0]          rdata2,
   output logic [DATA_W-1:0]          rdata3,
   output logic                       ready,
   output logic                       wr_drop
);

   localparam int DEPTH   = 2**ADDR_W;
   localparam int N_LANES = DATA_W / LANE_W;

   generate
      if ((DATA_W % LANE_W) != 0) begin : g_bad_lane_w
         $error("regfile_mp: DATA_W must be an integer multiple of LANE_W");
      end
   endgenerate

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   merged;
   logic [DATA_W-1:0]   rd1_d, rd2_d, rd3_d;
   logic                is_ready, r0_target, wr_en, drop_d, rd_keep;

   assign is_ready  = (state_q == S_READY);
   assign ready     = is_ready;
   // Writes to a hard-wired zero entry vanish silently, in or out of READY.
   assign r0_target = (ZERO_R0 != 0) && (waddr == '0);
   assign wr_en     = is_ready && we && (|wmask) && !r0_target;
   assign drop_d    = !is_ready && we && (|wmask) && !r0_target;
   // Reads only survive when this cycle and the next are both READY, so the
   // first READY cycle after a sweep and the first CLEAR cycle both show zero.
   assign rd_keep   = is_ready && !clr;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_CLEAR: begin
            if (ptr_q == ADDR_W'(DEPTH-1)) state_d = S_READY;
            else                           ptr_d   = ptr_q + ADDR_W'(1);
         end
         S_READY: begin
            if (clr) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = S_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_comb begin
      merged = mem[waddr];
      for (int i = 0; i < N_LANES; i++) begin
         if (wmask[i]) merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
      end
   end

   always_comb begin
      rd1_d = (wr_en && raddr1 == waddr) ? merged : mem[raddr1];
      rd2_d = (wr_en && raddr2 == waddr) ? merged : mem[raddr2];
      rd3_d = wr_en ? merged : mem[waddr];
      if (ZERO_R0 != 0 && raddr1 == '0) rd1_d = '0;
      if (ZERO_R0 != 0 && raddr2 == '0) rd2_d = '0;
      if (r0_target)                    rd3_d = '0;
      if (!rd_keep) begin
         rd1_d = '0;
         rd2_d = '0;
         rd3_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
         rdata1  <= '0;
         rdata2  <= '0;
         rdata3  <= '0;
         wr_drop <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rdata1  <= rd1_d;
         rdata2  <= rd2_d;
         rdata3  <= rd3_d;
         wr_drop <= drop_d;
      end
   end

   // Array has no reset; it is zeroed only by the sweep.
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR)  mem[ptr_q] <= '0;
      else if (wr_en)          mem[waddr] <= merged;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance and a ZERO_R0=1 instance share all inputs.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  raddr1 = '0, raddr2 = '0, waddr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  wmask = '0;
   logic [31:0] rdata1, rdata2, rdata3, rz1, rz2, rz3;
   logic        ready, wr_drop, ready_z, wr_drop_z;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .reset(reset), .clr(clr), .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr),
      .wdata(wdata), .wmask(wmask), .we(we), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
      .ready(ready), .wr_drop(wr_drop)
   );

   regfile_mp #(.ZERO_R0(1)) dut_z (
      .clk(clk), .reset(reset), .clr(clr), .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr),
      .wdata(wdata), .wmask(wmask), .we(we), .rdata1(rz1), .rdata2(rz2), .rdata3(rz3),
      .ready(ready_z), .wr_drop(wr_drop_z)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [1:0] m);
      waddr = a; wdata = d; wmask = m; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [31:0] dz);
      raddr1 = a;
      step();
      d  = rdata1;
      dz = rz1;
   endtask

   task automatic count_to_ready(input int start, output int n);
      n = start;
      while (!ready && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d, dz;
      int n;
      reset = 1'b1;
      #12;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b expected 0", wr_drop); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", rdata1); end
      step();
      reset = 1'b0;
      count_to_ready(0, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL reset_sweep_len: got %0d expected 16", n); end
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), d, dz);
         checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_zero r%0d: got %h expected 0", a, d); end
      end
   endtask

   task automatic test_lane_merge();
      logic [31:0] d, dz;
      do_write(4'd5, 32'hDEADBEEF, 2'b11);
      checks++; if (rdata3 !== 32'hDEADBEEF) begin errors++; $display("FAIL merge_full: got %h expected deadbeef", rdata3); end
      do_write(4'd5, 32'h1234ABCD, 2'b01);
      checks++; if (rdata3 !== 32'hDEADABCD) begin errors++; $display("FAIL merge_lo bypass: got %h expected deadabcd", rdata3); end
      do_read(4'd5, d, dz);
      checks++; if (d !== 32'hDEADABCD) begin errors++; $display("FAIL merge_lo read: got %h expected deadabcd", d); end
      do_write(4'd5, 32'h55557777, 2'b10);
      checks++; if (rdata3 !== 32'h5555ABCD) begin errors++; $display("FAIL merge_hi: got %h expected 5555abcd", rdata3); end
      do_write(4'd5, 32'hFFFFFFFF, 2'b00);
      checks++; if (rdata3 !== 32'h5555ABCD) begin errors++; $display("FAIL merge_none: got %h expected 5555abcd", rdata3); end
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL merge_none_drop: got %b expected 0", wr_drop); end
   endtask

   task automatic test_bypass();
      raddr1 = 4'd3; raddr2 = 4'd3;
      do_write(4'd3, 32'hCAFEF00D, 2'b11);
      checks++; if (rdata1 !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_rd1: got %h expected cafef00d", rdata1); end
      checks++; if (rdata2 !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_rd2: got %h expected cafef00d", rdata2); end
      checks++; if (rdata3 !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_rd3: got %h expected cafef00d", rdata3); end
      raddr1 = 4'd5;
      step();
      checks++; if (rdata1 !== 32'h5555ABCD) begin errors++; $display("FAIL two_port rd1: got %h expected 5555abcd", rdata1); end
      checks++; if (rdata2 !== 32'hCAFEF00D) begin errors++; $display("FAIL two_port rd2: got %h expected cafef00d", rdata2); end
   endtask

   task automatic test_zero_r0();
      logic [31:0] d, dz;
      do_write(4'd0, 32'hFFFFFFFF, 2'b11);
      checks++; if (rz3 !== 32'h0) begin errors++; $display("FAIL zr0_bypass: got %h expected 0", rz3); end
      checks++; if (rdata3 !== 32'hFFFFFFFF) begin errors++; $display("FAIL r0_normal: got %h expected ffffffff", rdata3); end
      checks++; if (wr_drop_z !== 1'b0) begin errors++; $display("FAIL zr0_drop: got %b expected 0", wr_drop_z); end
      do_read(4'd0, d, dz);
      checks++; if (dz !== 32'h0) begin errors++; $display("FAIL zr0_read: got %h expected 0", dz); end
      checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL r0_read: got %h expected ffffffff", d); end
      do_write(4'd1, 32'hA5A55A5A, 2'b11);
      do_read(4'd1, d, dz);
      checks++; if (dz !== 32'hA5A55A5A) begin errors++; $display("FAIL zr0_r1: got %h expected a5a55a5a", dz); end
   endtask

   task automatic test_clear_drop();
      logic [31:0] d, dz;
      int n;
      raddr1 = 4'd1; raddr2 = 4'd3;
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", ready); end
      checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL clr_rdata2: got %h expected 0", rdata2); end
      step();
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL clr_rdata1: got %h expected 0", rdata1); end
      do_write(4'd5, 32'h0BAD0BAD, 2'b11);
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL clr_drop_pulse: got %b expected 1", wr_drop); end
      step();
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL clr_drop_end: got %b expected 0", wr_drop); end
      count_to_ready(3, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL clr_sweep_len: got %0d expected 16", n); end
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), d, dz);
         checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_zero r%0d: got %h expected 0", a, d); end
      end
   endtask

   task automatic test_clr_with_write();
      logic [31:0] d, dz;
      waddr = 4'd7; wdata = 32'h77778888; wmask = 2'b11; we = 1'b1; clr = 1'b1;
      step();
      we = 1'b0; clr = 1'b0;
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL clrwe_drop: got %b expected 0", wr_drop); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clrwe_ready: got %b expected 0", ready); end
      checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL clrwe_rdata3: got %h expected 0", rdata3); end
      for (int k = 1; k < 16; k++) step();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL edge_ready_pre: got %b expected 0", ready); end
      do_write(4'd9, 32'h99999999, 2'b11);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL edge_ready_post: got %b expected 1", ready); end
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL edge_drop: got %b expected 1", wr_drop); end
      do_read(4'd9, d, dz);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_r9: got %h expected 0", d); end
      do_read(4'd7, d, dz);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL clrwe_r7: got %h expected 0", d); end
   endtask

   task automatic test_reset_async();
      logic [31:0] d, dz;
      int n;
      do_write(4'd14, 32'hE0E0E0E0, 2'b11);
      do_read(4'd14, d, dz);
      checks++; if (d !== 32'hE0E0E0E0) begin errors++; $display("FAIL async_pre: got %h expected e0e0e0e0", d); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL async_rdata1: got %h expected 0", rdata1); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", ready); end
      step();
      step();
      reset = 1'b0;
      count_to_ready(0, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL async_sweep_len: got %0d expected 16", n); end
      do_read(4'd14, d, dz);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_r14: got %h expected 0", d); end
   endtask

   task automatic test_reset_mid_clear();
      logic [31:0] d, dz;
      int n;
      do_write(4'd12, 32'hC0C0C0C0, 2'b11);
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int k = 0; k < 7; k++) step();
      reset = 1'b1;
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midclr_ready: got %b expected 0", ready); end
      step();
      step();
      reset = 1'b0;
      count_to_ready(0, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL midclr_sweep_len: got %0d expected 16", n); end
      do_read(4'd12, d, dz);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL midclr_r12: got %h expected 0", d); end
   endtask

   initial begin
      test_reset();
      test_lane_merge();
      test_bypass();
      test_zero_r0();
      test_clear_drop();
      test_clr_with_write();
      test_reset_async();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
